mux2b_4to1: RTL and testbench

Registered 2-bit-wide 4-to-1 multiplexer. One of four 2-bit data words is routed to the output under a 2-bit select. A combinational result and a clocked, reset-able copy are both provided. The datapath is built twice, as a behavioural select and as an explicit AND/OR/NOT gate network, so the two implementations can be cross-checked in silicon. The block sits between a small data source and any consumer that needs either an immediate or a registered 2-bit selection.

---
 rtl/mux2b_pkg.sv | 10 +
 rtl/mux4to1_gate.sv | 31 +++
 rtl/mux2b_4to1.sv | 59 +++++
 tb/tb_mux2b_4to1.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux2b_pkg.sv
// mux2b_pkg: shared word/select types and select codes for the 2-bit 4:1 mux
// Contents: word_t (2-bit data word), sel_t (2-bit select), SEL_A..SEL_D codes.
package mux2b_pkg;
    typedef logic [1:0] word_t;
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;
endpackage

// File: rtl/mux4to1_gate.sv
// mux4to1_gate: 1-bit 4:1 mux built only from NOT/AND/OR primitives
// Ports: sel (2-bit select), d0..d3 (data bits for sel 00..11), y (selected bit).
module mux4to1_gate
    import mux2b_pkg::*;
(
    input  sel_t sel,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    output logic y
);
    logic ns1, ns0;
    logic dec0, dec1, dec2, dec3;
    logic p0, p1, p2, p3;

    not u_n1 (ns1, sel[1]);
    not u_n0 (ns0, sel[0]);

    and u_dec0 (dec0, ns1, ns0);
    and u_dec1 (dec1, ns1, sel[0]);
    and u_dec2 (dec2, sel[1], ns0);
    and u_dec3 (dec3, sel[1], sel[0]);

    and u_p0 (p0, dec0, d0);
    and u_p1 (p1, dec1, d1);
    and u_p2 (p2, dec2, d2);
    and u_p3 (p3, dec3, d3);

    or u_or (y, p0, p1, p2, p3);
endmodule

// File: rtl/mux2b_4to1.sv
// mux2b_4to1: registered 2-bit 4:1 mux with gate-level datapath and optional cross-check
// Ports: clk, rst_n (async active-low), a/b/c/d (data words for sel 00..11), sel,
//        y_comb (gate-level result), y_q (registered y_comb), mismatch (sticky flag).
// Build option: define MUX2B_XCHECK_EN to add the behavioural path and the
// registered, sticky y_beh/y_comb disagreement flag; otherwise mismatch is 0.
module mux2b_4to1
    import mux2b_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    input  sel_t  sel,
    output word_t y_comb,
    output word_t y_q,
    output logic  mismatch
);
    for (genvar i = 0; i < 2; i++) begin : g_bit
        mux4to1_gate u_gate (
            .sel (sel),
            .d0  (a[i]),
            .d1  (b[i]),
            .d2  (c[i]),
            .d3  (d[i]),
            .y   (y_comb[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) y_q <= '0;
        else        y_q <= y_comb;

`ifdef MUX2B_XCHECK_EN
    word_t y_beh;

    // case rather than a ternary chain so an X/Z select falls to default 00
    always_comb begin
        case (sel)
            SEL_A:   y_beh = a;
            SEL_B:   y_beh = b;
            SEL_C:   y_beh = c;
            SEL_D:   y_beh = d;
            default: y_beh = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                 mismatch <= 1'b0;
        else if (y_beh != y_comb)   mismatch <= 1'b1;

`ifndef SYNTHESIS
    a_xcheck: assert property (@(posedge clk) disable iff (!rst_n) y_beh == y_comb);
`endif
`else
    assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_mux2b_4to1.sv
// tb_mux2b_4to1: scoreboard bench for mux2b_4to1 (directed vectors plus full sweep)
module tb_mux2b_4to1;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] a, b, c, d, sel;
    logic [1:0] y_comb, y_q;
    logic       mismatch;

    mux2b_4to1 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .sel      (sel),
        .y_comb   (y_comb),
        .y_q      (y_q),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] comb;
        logic [1:0] q;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail = 0;
    logic [1:0] q_model = 2'b00;
    logic [9:0] v;
    logic [1:0] ev;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // drive one vector just after an edge; y_q during this cycle is the
    // selection presented before the edge, tracked in q_model
    task automatic apply(input logic [1:0] va, input logic [1:0] vb, input logic [1:0] vc,
                         input logic [1:0] vd, input logic [1:0] vs, input logic [1:0] exp);
        @(posedge clk);
        #1;
        a = va; b = vb; c = vc; d = vd; sel = vs;
        sb.push_back('{cyc, exp, q_model});
        q_model = exp;
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("y_comb", y_comb, e.comb);
            chk("y_q", y_q, e.q);
            chk("mismatch", {1'b0, mismatch}, 2'b00);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        a = 2'b00; b = 2'b01; c = 2'b10; d = 2'b11; sel = 2'b00;
        #12;
        chk("reset y_q", y_q, 2'b00);
        chk("reset mismatch", {1'b0, mismatch}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        apply(2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00);
        apply(2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b01);
        apply(2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10);
        apply(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11);
        apply(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset y_q", y_q, 2'b00);
        chk("async reset mismatch", {1'b0, mismatch}, 2'b00);
        chk("y_comb during reset", y_comb, 2'b11);
        @(posedge clk);
        #1;
        chk("reset hold y_q", y_q, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first edge after reset", y_q, 2'b11);

        apply(2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00);
        apply(2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11);
        apply(2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01);
        apply(2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01);

        apply(2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b00);
        apply(2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10);
        apply(2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11);

        for (int i = 0; i < 1024; i++) begin
            v = i[9:0];
            ev = (v[9:8] == 2'b00) ? v[1:0] :
                 (v[9:8] == 2'b01) ? v[3:2] :
                 (v[9:8] == 2'b10) ? v[5:4] : v[7:6];
            apply(v[1:0], v[3:2], v[5:4], v[7:6], v[9:8], ev);
        end

        apply(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

`ifdef MUX2B_XCHECK_EN
        @(posedge clk);
        #1;
        force dut.y_comb[0] = 1'b1;
        @(posedge clk);
        #1;
        release dut.y_comb[0];
        chk("xcheck set", {1'b0, mismatch}, 2'b01);
        repeat (3) @(posedge clk);
        #1;
        chk("xcheck sticky", {1'b0, mismatch}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("xcheck cleared", {1'b0, mismatch}, 2'b00);
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
